// File: rtl/rr_arb_dec8.sv
// Round-robin arbiter for 8 requesters with registered binary select and one-hot grant.
// Optional watchdog compiled in by defining RR_ARB_TIMEOUT_EN.
module rr_arb_dec8 #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] s,
    output logic       enable,
    output logic [7:0] grant,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] s_nxt;
    logic [2:0] pick;
    logic       found;
    logic       release_n;
    logic       release_t;

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("rr_arb_dec8: TIMEOUT must be in 2..255");
    end

    // First set request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!found && req[ptr + 3'(i)]) begin
                pick  = ptr + 3'(i);
                found = 1'b1;
            end
        end
    end

    assign release_n = (state == GRANT) && (done || !req[s]);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        s_nxt     = s;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    s_nxt     = pick;
                end
            end
            GRANT: begin
                if (release_n || release_t) begin
                    state_nxt = IDLE;
                    ptr_nxt   = s + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            s     <= '0;
            grant <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            s     <= s_nxt;
            grant <= (state_nxt == GRANT) ? (8'd1 << s_nxt) : '0;
        end
    end

    assign enable = (state == GRANT);

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] cnt;
    logic       timeout_q;

    // cnt is zero in the first GRANT cycle, so release lands on GRANT cycle TIMEOUT.
    assign release_t = (state == GRANT) && !release_n && (cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= release_t;
            cnt       <= ((state == GRANT) && (state_nxt == GRANT)) ? cnt + 8'd1 : '0;
        end
    end

    assign timeout = timeout_q;
`else
    assign release_t = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb_dec8.sv
// Scoreboard bench for rr_arb_dec8: driver pushes model predictions, monitor pops and compares.
module tb_rr_arb_dec8;

    localparam int TB_TIMEOUT = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [2:0] s;
    logic       enable;
    logic [7:0] grant;
    logic       timeout;

    rr_arb_dec8 #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .s       (s),
        .enable  (enable),
        .grant   (grant),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       en;
        logic [2:0] s;
        logic [7:0] g;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    // Reference model: who owns the resource, where the search starts, how long held.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_age   = 0;
    bit m_to    = 1'b0;

    task automatic model_edge(input logic r, input logic [7:0] rq, input logic d);
        exp_t e;
        if (r) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_age = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (!m_busy) begin
                if (rq != 8'h00) begin
                    for (int k = 0; k < 8; k++) begin
                        if (rq[(m_ptr + k) % 8]) begin
                            m_owner = (m_ptr + k) % 8;
                            break;
                        end
                    end
                    m_busy = 1'b1;
                    m_age  = 0;
                end
            end else begin
                m_age++;
                if (d || !rq[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % 8;
                end else if (TO_EN && m_age >= TB_TIMEOUT) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % 8;
                    m_to   = 1'b1;
                end
            end
        end
        e.en = m_busy;
        e.s  = 3'(m_owner);
        e.g  = m_busy ? 8'(1 << m_owner) : 8'h00;
        e.to = m_to;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [12:0] act, input logic [12:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s t=%0t actual {en,s,grant,to}=%013b required %013b", name, $time, act, req_v);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, sampled on the next rising edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic d);
        logic was_rst;
        @(negedge clk);
        was_rst = rst;
        rst  = r;
        req  = rq;
        done = d;
        if (r && !was_rst) begin
            #1;
            check_now("async_reset", {enable, s, grant, timeout}, 13'd0);
        end
        model_edge(r, rq, d);
        mon_en = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty t=%0t actual no prediction required one", $time);
                end else begin
                    e = exp_q.pop_front();
                    if ({enable, s, grant, timeout} !== e) begin
                        n_fail++;
                        $display("FAIL grant_out t=%0t actual en=%0b s=%0d grant=%08b to=%0b required en=%0b s=%0d grant=%08b to=%0b",
                                 $time, enable, s, grant, timeout, e.en, e.s, e.g, e.to);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog t=%0t actual still running required finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [7:0] rq;
        logic       r;
        #1;
        check_now("reset_state", {enable, s, grant, timeout}, 13'd0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);

        // Single requester from reset, then release.
        step(1'b0, 8'h04, 1'b0);
        step(1'b0, 8'h04, 1'b0);
        step(1'b0, 8'h04, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Full rotation from reset with done every cycle.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'hFF, 1'b1);

        // No preemption: owner 5 keeps the grant while 7 and 0 wait.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h20, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'hA1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'hA1, 1'b1);

        // Long hold without done: watchdog release when compiled in, else held.
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 8'h08, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h18, 1'b0);
        step(1'b0, 8'h00, 1'b0);

        // Timeout coinciding with done counts as a normal release.
        for (int i = 0; i < TB_TIMEOUT - 1; i++) step(1'b0, 8'h02, 1'b0);
        step(1'b0, 8'h02, 1'b0);
        step(1'b0, 8'h02, 1'b1);
        step(1'b0, 8'h00, 1'b0);

        // Reset mid-grant at owner 6, then all requesting restarts at 0.
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h40, 1'b0);
        step(1'b0, 8'h40, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        step(1'b0, 8'hFF, 1'b1);

        // Randomized traffic with sticky requests and occasional resets.
        rq = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) rq = 8'($urandom);
            if ($urandom_range(15, 0) == 0) rq = 8'h00;
            r = ($urandom_range(63, 0) == 0);
            step(r, rq, ($urandom_range(4, 0) == 0));
        end

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual %0d left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
